// File: rtl/leaf_stream_tx.sv
// Credit-based producer-to-BFT packet transmitter for a single leaf.
// It stamps each accepted payload with a route and a sequence address, and it refills credits from receiver updates.
module leaf_stream_tx #(
    parameter int unsigned PACKET_BITS           = 49,
    parameter int unsigned PAYLOAD_BITS          = 32,
    parameter int unsigned NUM_LEAF_BITS         = 5,
    parameter int unsigned NUM_PORT_BITS         = 4,
    parameter int unsigned NUM_ADDR_BITS         = 7,
    parameter int unsigned NUM_BRAM_ADDR_BITS    = 7,
    parameter int unsigned FREESPACE_UPDATE_SIZE = 64,
    parameter int unsigned DEST_LEAF             = 2,
    parameter int unsigned DEST_PORT             = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [PACKET_BITS-1:0]        din_leaf_bft2interface,
    output logic [PACKET_BITS-1:0]        dout_leaf_interface2bft,
    input  logic [PAYLOAD_BITS-1:0]       din_leaf_user2interface,
    input  logic                          vld_user2interface,
    output logic                          ack_interface2user,
    input  logic                          resend,
    output logic [NUM_BRAM_ADDR_BITS:0]   credit_count,
    output logic [31:0]                   pkt_count,
    output logic [31:0]                   stall_count
);

    localparam int unsigned CW         = NUM_BRAM_ADDR_BITS + 1;
    localparam int unsigned SW         = CW + 1;
    localparam int unsigned MAX_CREDIT = 2 ** NUM_BRAM_ADDR_BITS;
    localparam int unsigned VLD_BIT    = PACKET_BITS - 1;
    localparam int unsigned LEAF_LSB   = VLD_BIT - NUM_LEAF_BITS;
    localparam int unsigned PORT_LSB   = LEAF_LSB - NUM_PORT_BITS;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_BLOCKED = 2'd1,
        ST_RESYNC  = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [CW-1:0]            credit_q, credit_d;
    logic [NUM_ADDR_BITS-1:0] seq_q, seq_d;
    logic [PACKET_BITS-1:0]   dout_q, dout_d;
    logic [31:0]              pkt_q, pkt_d;
    logic [31:0]              stall_q, stall_d;

    logic                     credit_upd_c;
    logic                     accept_c;
    logic [SW-1:0]            credit_sum_c;
    logic [CW-1:0]            credit_sat_c;
    logic                     unused_bft_c;

    // Credit returns are addressed to this leaf on port 0; everything else is traffic to ignore.
    assign credit_upd_c = din_leaf_bft2interface[VLD_BIT]
                       && (din_leaf_bft2interface[VLD_BIT-1 -: NUM_LEAF_BITS] == NUM_LEAF_BITS'(DEST_LEAF))
                       && (din_leaf_bft2interface[LEAF_LSB-1 -: NUM_PORT_BITS] == '0);
    assign unused_bft_c = ^din_leaf_bft2interface[PORT_LSB-1:0];

    // A resend in the same cycle cancels the accept; reset also masks it so that ack stays low while reset is held.
    assign accept_c = reset && vld_user2interface && (state_q == ST_RUN)
                   && (credit_q != '0) && !resend;

    assign credit_sum_c = SW'(credit_q)
                        + (credit_upd_c ? SW'(FREESPACE_UPDATE_SIZE) : SW'(0))
                        - SW'(accept_c);
    assign credit_sat_c = (credit_sum_c > SW'(MAX_CREDIT)) ? CW'(MAX_CREDIT) : CW'(credit_sum_c);

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        seq_d    = seq_q;
        dout_d   = '0;
        pkt_d    = pkt_q;
        stall_d  = stall_q;

        if ((state_q == ST_BLOCKED) && vld_user2interface && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end

        if (resend) begin
            state_d  = ST_RESYNC;
            credit_d = CW'(MAX_CREDIT);
            seq_d    = '0;
        end else if (state_q == ST_RESYNC) begin
            // Credit updates that arrive during RESYNC are discarded; the buffer counts as empty.
            state_d  = ST_RUN;
            credit_d = CW'(MAX_CREDIT);
            seq_d    = '0;
        end else begin
            credit_d = credit_sat_c;
            state_d  = (credit_sat_c == '0) ? ST_BLOCKED : ST_RUN;
            if (accept_c) begin
                dout_d = PACKET_BITS'({1'b1,
                                       NUM_LEAF_BITS'(DEST_LEAF),
                                       NUM_PORT_BITS'(DEST_PORT),
                                       seq_q,
                                       din_leaf_user2interface});
                seq_d  = seq_q + NUM_ADDR_BITS'(1);
                pkt_d  = pkt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RUN;
            credit_q <= CW'(MAX_CREDIT);
            seq_q    <= '0;
            dout_q   <= '0;
            pkt_q    <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            seq_q    <= seq_d;
            dout_q   <= dout_d;
            pkt_q    <= pkt_d;
            stall_q  <= stall_d;
        end
    end

    assign dout_leaf_interface2bft = dout_q;
    assign ack_interface2user      = accept_c;
    assign credit_count            = credit_q;
    assign pkt_count               = pkt_q;
    assign stall_count             = stall_q;

endmodule

// File: doc/leaf_stream_tx.md
LEAF_STREAM_TX -- requirements
Module: leaf_stream_tx

Interface
REQ-001 The block SHALL have parameters, one per line: name, default, meaning.
- PACKET_BITS, 49, BFT packet width.
- PAYLOAD_BITS, 32, payload width.
- NUM_LEAF_BITS, 5, destination leaf field width.
- NUM_PORT_BITS, 4, destination port field width.
- NUM_ADDR_BITS, 7, sequence-address field width.
- NUM_BRAM_ADDR_BITS, 7, receiver buffer depth is 2^7 = 128 words.
- FREESPACE_UPDATE_SIZE, 64, credits returned per credit-update packet.
- DEST_LEAF, 2, destination leaf.
- DEST_PORT, 1, destination port; must be nonzero.
REQ-002 The block SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1, the single clock.
- reset, in, 1, asynchronous active-low reset.
- din_leaf_bft2interface, in, 49, packets arriving from the BFT (credit returns).
- dout_leaf_interface2bft, out, 49, packets sent to the BFT.
- din_leaf_user2interface, in, 32, producer payload.
- vld_user2interface, in, 1, producer valid.
- ack_interface2user, out, 1, accept pulse to the producer.
- resend, in, 1, resynchronise request.
- credit_count, out, 8, current credit count.
- pkt_count, out, 32, packets sent since reset.
- stall_count, out, 32, cycles spent in BLOCKED.
REQ-003 Packet format SHALL be:
- [48] valid.
- [47:43] leaf.
- [42:39] port.
- [38:32] sequence address.
- [31:0] payload.

Function
REQ-004 A producer word SHALL be accepted in cycle N iff vld_user2interface=1, state=RUN and credit_count>0; ack_interface2user SHALL be 1 in cycle N only, as a combinational function of these registered conditions.
REQ-005 The producer SHALL hold data and valid until ack is seen; the block SHALL never ack without vld.
REQ-006 A word accepted in cycle N SHALL appear on dout_leaf_interface2bft in cycle N+1 for exactly one cycle, as {1, DEST_LEAF, DEST_PORT, seq_addr, payload}.
REQ-007 Cycles without an accept SHALL drive dout_leaf_interface2bft = 0.
REQ-008 Sustained throughput SHALL be one packet per cycle while credit_count>0; the BFT side has no back-pressure.
REQ-009 seq_addr SHALL start at 0 and increment by 1 per sent packet, wrapping 127 to 0.
REQ-010 An incoming packet with bit[48]=1, leaf field=DEST_LEAF and port field=0 SHALL be a credit update adding FREESPACE_UPDATE_SIZE credits.
REQ-011 All other incoming packets SHALL be ignored.
REQ-012 Credits SHALL saturate at 128.
REQ-013 An accept SHALL decrement the credit count by 1.
REQ-014 A credit update and an accept in the same cycle SHALL yield credit_count = min(128, credit - 1 + 64).
REQ-015 The FSM SHALL have three states: RUN, BLOCKED and RESYNC.
- RUN to BLOCKED when the next credit value is 0.
- BLOCKED to RUN when the next credit value is greater than 0.
- Any state to RESYNC when resend=1.
- RESYNC to RUN after exactly one cycle.
REQ-016 RESYNC SHALL force seq_addr=0, credit_count=128 and no ack; a credit update arriving during RESYNC SHALL be discarded.
REQ-017 A resend pulse in the same cycle as an accept SHALL cancel that accept: no ack and no packet.
REQ-018 stall_count SHALL increment on each cycle in BLOCKED with vld_user2interface=1, saturating at 2^32-1.
REQ-019 pkt_count SHALL increment per sent packet, wrapping at 2^32.

Reset
REQ-020 While reset=0, the block SHALL be forced asynchronously to:
- state=RUN.
- credit_count=128.
- seq_addr=0.
- pkt_count=0.
- stall_count=0.
- dout_leaf_interface2bft=0.
- ack_interface2user=0.
REQ-021 Release of reset SHALL be taken synchronously; the first accept is possible in the first clock edge after release.
REQ-022 Reset asserted mid-burst SHALL drop any packet pending for N+1 output.

Verification
REQ-023 Reset, then vld held with payloads 0xA0..0xA3 -> acks in 4 consecutive cycles, each one cycle before its packet; seq 0..3, credit_count=124, pkt_count=4.
REQ-024 130 words continuously, no credit returns -> exactly 128 packets with seq 0..127, then state=BLOCKED and stall_count counting; inject a credit packet {1,DEST_LEAF,0,0,0} -> credit=64, the next packet has seq 0 (wrap), and sending resumes.
REQ-025 Credit packet and accept in the same cycle with credit=100 -> credit_count=128 (saturation).
REQ-026 Packets with wrong leaf or port=1 -> credit unchanged, output unaffected.
REQ-027 resend pulse during a burst at seq=37 -> no ack that cycle, next packet seq=0, credit_count=127 afterward.
REQ-028 reset asserted while vld=1 mid-burst -> outputs are 0 immediately (asynchronous), all counters are 0 after release.
